// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with flush-to-zero, round-to-nearest-even,
// special-operand handling and a stall-all valid/ready stream interface.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [3:0]             out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_special_q, s1_special_d;
  logic                 s1_invalid_q, s1_invalid_d;
  logic [W-1:0]         s1_spec_q, s1_spec_d;
  logic [MAN_W:0]       s1_man_a_q, s1_man_a_d;
  logic [MAN_W:0]       s1_man_b_q, s1_man_b_d;
  logic signed [XW-1:0] s1_exp_q, s1_exp_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_special_q, s2_special_d;
  logic                 s2_invalid_q, s2_invalid_d;
  logic [W-1:0]         s2_spec_q, s2_spec_d;
  logic [PW-1:0]        s2_prod_q, s2_prod_d;
  logic signed [XW-1:0] s2_exp_q, s2_exp_d;

  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic [3:0]           out_flags_q, out_flags_d;

  logic                 a_sign, b_sign, p_sign;
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_frac, b_frac;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic                 prod_msb, guard, sticky, round_up, carry, inexact;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       frac_r;
  logic signed [XW-1:0] exp_n;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

  always_comb begin
    {a_sign, a_exp, a_frac} = in_a;
    {b_sign, b_exp, b_frac} = in_b;
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    p_sign = a_sign ^ b_sign;

    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_special_d = s1_special_q;
    s1_invalid_d = s1_invalid_q;
    s1_spec_d    = s1_spec_q;
    s1_man_a_d   = s1_man_a_q;
    s1_man_b_d   = s1_man_b_q;
    s1_exp_d     = s1_exp_q;
    if (adv) begin
      s1_valid_d   = in_valid;
      s1_sign_d    = p_sign;
      s1_man_a_d   = {1'b1, a_frac};
      s1_man_b_d   = {1'b1, b_frac};
      s1_exp_d     = signed'({2'b00, a_exp}) + signed'({2'b00, b_exp}) - BIAS;
      s1_special_d = 1'b1;
      s1_invalid_d = 1'b0;
      // Denormal operands have exp==0 and are therefore already classed as zero.
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
        s1_spec_d    = QNAN;
        s1_invalid_d = 1'b1;
      end else if (a_inf || b_inf) begin
        s1_spec_d = {p_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        s1_spec_d = {p_sign, {(W-1){1'b0}}};
      end else begin
        s1_special_d = 1'b0;
        s1_spec_d    = '0;
      end
    end
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_sign_d    = s2_sign_q;
    s2_special_d = s2_special_q;
    s2_invalid_d = s2_invalid_q;
    s2_spec_d    = s2_spec_q;
    s2_prod_d    = s2_prod_q;
    s2_exp_d     = s2_exp_q;
    if (adv) begin
      s2_valid_d   = s1_valid_q;
      s2_sign_d    = s1_sign_q;
      s2_special_d = s1_special_q;
      s2_invalid_d = s1_invalid_q;
      s2_spec_d    = s1_spec_q;
      s2_prod_d    = PW'(s1_man_a_q) * PW'(s1_man_b_q);
      s2_exp_d     = s1_exp_q;
    end
  end

  always_comb begin
    prod_msb = s2_prod_q[PW-1];
    frac     = prod_msb ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
    guard    = prod_msb ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    sticky   = prod_msb ? (|s2_prod_q[MAN_W-1:0]) : (|s2_prod_q[MAN_W-2:0]);
    round_up = guard & (sticky | frac[0]);
    // A carry out of the fraction leaves it all-zero, i.e. mantissa 1.0 one binade up.
    frac_r   = {1'b0, frac} + (MAN_W+1)'(round_up);
    carry    = frac_r[MAN_W];
    exp_n    = s2_exp_q + XW'(prod_msb) + XW'(carry);
    inexact  = guard | sticky;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      out_data_d  = '0;
      out_flags_d = '0;
      if (s2_valid_q) begin
        if (s2_special_q) begin
          out_data_d  = s2_spec_q;
          out_flags_d = {s2_invalid_q, 3'b000};
        end else if (exp_n >= EXP_MAX) begin
          out_data_d  = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
          out_flags_d = 4'b0101;
        end else if (exp_n < EXP_ONE) begin
          out_data_d  = {s2_sign_q, {(W-1){1'b0}}};
          out_flags_d = 4'b0011;
        end else begin
          out_data_d  = {s2_sign_q, exp_n[EXP_W-1:0], frac_r[MAN_W-1:0]};
          out_flags_d = {3'b000, inexact};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_invalid_q <= 1'b0;
      s1_spec_q    <= '0;
      s1_man_a_q   <= '0;
      s1_man_b_q   <= '0;
      s1_exp_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_special_q <= 1'b0;
      s2_invalid_q <= 1'b0;
      s2_spec_q    <= '0;
      s2_prod_q    <= '0;
      s2_exp_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_special_q <= s1_special_d;
      s1_invalid_q <= s1_invalid_d;
      s1_spec_q    <= s1_spec_d;
      s1_man_a_q   <= s1_man_a_d;
      s1_man_b_q   <= s1_man_b_d;
      s1_exp_q     <= s1_exp_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_special_q <= s2_special_d;
      s2_invalid_q <= s2_invalid_d;
      s2_spec_q    <= s2_spec_d;
      s2_prod_q    <= s2_prod_d;
      s2_exp_q     <= s2_exp_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (single precision): expected results are queued when an
// operand pair is accepted and popped when the DUT hands a result downstream.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb_q[$];

  logic [31:0] arith_a [0:5] = '{32'hBFC00000, 32'h3F800001, 32'h7F800000,
                                 32'hFF800000, 32'h7F000000, 32'h00800000};
  logic [31:0] arith_b [0:5] = '{32'h40000000, 32'h3F800001, 32'h00000000,
                                 32'h40000000, 32'h40000000, 32'h3F000000};
  logic [31:0] arith_p [0:5] = '{32'hC0400000, 32'h3F800002, 32'h7FC00000,
                                 32'hFF800000, 32'h7F800000, 32'h00000000};
  logic [3:0]  arith_f [0:5] = '{4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 4'b0011};

  // Operands 1.0 .. 8.0, each multiplied by 2.0
  logic [31:0] b2b_a [0:7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] b2b_p [0:7] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data);
    end
    checks++;
    if (out_flags !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_out_flags: got %b expected 0000", out_flags);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int cyc;
    logic [35:0] exp_e;
    sb_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 32'h40000000;
    in_b = 32'h40400000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_in_ready: got %b expected 1", in_ready);
    end
    if (in_valid && in_ready) sb_q.push_back({32'h40C00000, 4'b0000});
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("[TB] FAIL latency_cycles: got %0d expected 3", cyc);
    end
    if (out_valid === 1'b1 && sb_q.size() > 0) begin
      exp_e = sb_q.pop_front();
      checks++;
      if (out_data !== exp_e[35:4]) begin
        errors++;
        $display("[TB] FAIL latency_data: got %h expected %h", out_data, exp_e[35:4]);
      end
      checks++;
      if (out_flags !== exp_e[3:0]) begin
        errors++;
        $display("[TB] FAIL latency_flags: got %b expected %b", out_flags, exp_e[3:0]);
      end
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL latency_result: got none expected 40c00000");
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_single: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_arith();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [35:0] exp_e;
    sb_q.delete();
    while (got < 6 && cyc < 200) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = arith_a[sent];
        in_b = arith_b[sent];
      end
      #1;
      if (in_valid && in_ready) begin
        sb_q.push_back({arith_p[sent], arith_f[sent]});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL arith_extra: got %h expected no result", out_data);
        end else begin
          exp_e = sb_q.pop_front();
          if (out_data !== exp_e[35:4]) begin
            errors++;
            $display("[TB] FAIL arith_data[%0d]: got %h expected %h", got, out_data, exp_e[35:4]);
          end
          checks++;
          if (out_flags !== exp_e[3:0]) begin
            errors++;
            $display("[TB] FAIL arith_flags[%0d]: got %b expected %b", got, out_flags, exp_e[3:0]);
          end
          got++;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("[TB] FAIL arith_count: got %0d expected 6", got);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_cycles = 0;
    logic held_ok = 1'b0;
    logic [31:0] held_data = '0;
    logic [35:0] exp_e;
    sb_q.delete();
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_a = b2b_a[sent];
        in_b = 32'h40000000;
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_cycles++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_in_ready_stall: got %b expected 0", in_ready);
        end
        if (held_ok) begin
          checks++;
          if (out_data !== held_data) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got %h expected %h", out_data, held_data);
          end
        end else begin
          held_data = out_data;
          held_ok = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back({b2b_p[sent], 4'b0000});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_extra: got %h expected no result", out_data);
        end else begin
          exp_e = sb_q.pop_front();
          if (out_data !== exp_e[35:4] || out_flags !== exp_e[3:0]) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d]: got %h/%b expected %h/%b",
                     got, out_data, out_flags, exp_e[35:4], exp_e[3:0]);
          end
          got++;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 8", got);
    end
    checks++;
    if (stall_cycles != 4) begin
      errors++;
      $display("[TB] FAIL b2b_stall_cycles: got %0d expected 4", stall_cycles);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_duplicate: got out_valid %b data %h expected 0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_flush();
    int accepted = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = b2b_a[i];
      in_b = 32'h40400000;
      #1;
      if (in_valid && in_ready) accepted++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 3 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_fill: got %0d accepted, out_valid %b expected 3, 1", accepted, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_out_data: got %h expected 00000000", out_data);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_stale: got out_valid %b data %h expected 0", out_valid, out_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
